cp0_regfile: RTL

- Coprocessor-0 register file that sits directly downstream of the MEM-stage exception encoder.
- Consumes the encoded exception type, faulting PC and bad address, and commits architectural state: EPC, Cause, Status, BadVAddr.
- Implements the Count/Compare timer and its interrupt.
- Serves mfc0 reads and mtc0 writes; exports Status/Cause back to the encoder for interrupt qualification.

---
 rtl/cp0_regfile.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: EPC/Cause/Status/BadVAddr commit from the
// MEM-stage exception encoder, Count/Compare timer, mfc0/mtc0 access.
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  typedef enum logic [4:0] {
    REG_BADVADDR = 5'd8,
    REG_COUNT    = 5'd9,
    REG_COMPARE  = 5'd11,
    REG_STATUS   = 5'd12,
    REG_CAUSE    = 5'd13,
    REG_EPC      = 5'd14,
    REG_PRID     = 5'd15
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h01,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c,
    EXC_ERET = 5'h0e
  } exc_e;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_int_q, timer_int_d;
  logic        tick_q, tick_d;

  logic        exc_any;
  logic        exc_small;
  logic        wr_en;

  assign exc_any   = (excepttype_i != '0);
  assign exc_small = (excepttype_i[31:5] == '0);
  // Any pending exception drops a same-cycle mtc0 entirely.
  assign wr_en     = we_i && !exc_any;

  // Next-state: timer, interrupt sampling, mtc0 writes, then exception commit.
  always_comb begin
    tick_d      = ~tick_q;
    count_d     = tick_q ? count_q + 32'd1 : count_q;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    timer_int_d = timer_int_q;

    if ((count_q == compare_q) && (compare_q != '0)) begin
      timer_int_d = 1'b1;
    end

    cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};

    if (wr_en) begin
      case (waddr_i)
        REG_COUNT:   count_d = wdata_i;
        REG_COMPARE: begin
          compare_d   = wdata_i;
          timer_int_d = 1'b0;
        end
        REG_STATUS: begin
          status_d[15:8] = wdata_i[15:8];
          status_d[1:0]  = wdata_i[1:0];
        end
        REG_CAUSE:   cause_d[9:8] = wdata_i[9:8];
        REG_EPC:     epc_d = wdata_i;
        default: ;
      endcase
    end

    if (exc_small) begin
      case (excepttype_i[4:0])
        EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV: begin
          if (!status_q[1]) begin
            epc_d       = in_delayslot_i ? pc_i - 32'd4 : pc_i;
            cause_d[31] = in_delayslot_i;
          end
          status_d[1]  = 1'b1;
          cause_d[6:2] = (excepttype_i[4:0] == EXC_INT) ? 5'd0 : excepttype_i[4:0];
          if ((excepttype_i[4:0] == EXC_ADEL) || (excepttype_i[4:0] == EXC_ADES)) begin
            badvaddr_d = bad_addr_i;
          end
        end
        EXC_ERET: status_d[1] = 1'b0;
        default: ;
      endcase
    end

    // TI tracks the timer flop exactly by sharing its next-state value.
    cause_d[30] = timer_int_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q      <= 1'b0;
      count_q     <= '0;
      compare_q   <= '0;
      status_q    <= STATUS_RST;
      cause_q     <= '0;
      epc_q       <= '0;
      badvaddr_q  <= '0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      timer_int_q <= timer_int_d;
    end
  end

  // mfc0 read mux; unimplemented numbers read as zero.
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_q;
      REG_COMPARE:  rdata_o = compare_q;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause_q;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VALUE;
      default:      rdata_o = '0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int_q;

endmodule
